// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2), decode and execute (T3-T5), one step per clk.
// Drives every datapath strobe; unsupported opcodes flag illegal_op and retire as nop.
module control_sequencer #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    output logic        pc_out,
    output logic        pc_in,
    output logic        inc_pc,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        read,
    output logic        write,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        z_low_out,
    output logic        c_out,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic        instr_done,
    output logic        illegal_op
);

    typedef enum logic [2:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE, C_ITYPE, C_UNARY, C_NOP, C_HALT, C_ILLEGAL
    } op_class_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SHR = 4'b0100;
    localparam logic [3:0] ALU_SHL = 4'b0101;
    localparam logic [3:0] ALU_ROR = 4'b0110;
    localparam logic [3:0] ALU_ROL = 4'b0111;
    localparam logic [3:0] ALU_NEG = 4'b1010;
    localparam logic [3:0] ALU_NOT = 4'b1011;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t     state;
    logic [2:0] wait_cnt;
    op_class_t  op_class;
    logic [3:0] alu_code;
    logic [4:0] opcode;

    assign opcode = ir[31:27];

    // Register fields are decoded by the datapath via gra/grb/grc, not here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir[26:0];

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        op_class = C_ILLEGAL;
        alu_code = ALU_AND;
        case (opcode)
            5'b00011: begin op_class = C_RTYPE; alu_code = ALU_ADD; end
            5'b00100: begin op_class = C_RTYPE; alu_code = ALU_SUB; end
            5'b00101: begin op_class = C_RTYPE; alu_code = ALU_AND; end
            5'b00110: begin op_class = C_RTYPE; alu_code = ALU_OR;  end
            5'b00111: begin op_class = C_RTYPE; alu_code = ALU_SHR; end
            5'b01000: begin op_class = C_RTYPE; alu_code = ALU_SHL; end
            5'b01001: begin op_class = C_RTYPE; alu_code = ALU_ROR; end
            5'b01010: begin op_class = C_RTYPE; alu_code = ALU_ROL; end
            5'b01011: begin op_class = C_ITYPE; alu_code = ALU_ADD; end
            5'b01100: begin op_class = C_ITYPE; alu_code = ALU_AND; end
            5'b01101: begin op_class = C_ITYPE; alu_code = ALU_OR;  end
            5'b10000: begin op_class = C_UNARY; alu_code = ALU_NEG; end
            5'b10001: begin op_class = C_UNARY; alu_code = ALU_NOT; end
            5'b11001: op_class = C_NOP;
            5'b11010: op_class = C_HALT;
            default:  op_class = C_ILLEGAL;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RST;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_RST: state <= S_T0;
                S_T0: begin
                    state    <= S_T1;
                    wait_cnt <= '0;
                end
                S_T1: begin
                    if (wait_cnt == WAIT_LAST) state <= S_T2;
                    else                       wait_cnt <= wait_cnt + 3'd1;
                end
                S_T2: state <= S_T3;
                S_T3: begin
                    case (op_class)
                        C_RTYPE, C_ITYPE, C_UNARY: state <= S_T4;
                        C_HALT:                    state <= S_HALT;
                        default:                   state <= S_T0;
                    endcase
                end
                S_T4:    state <= (op_class == C_UNARY) ? S_T0 : S_T5;
                S_T5:    state <= S_T0;
                S_HALT:  state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    always_comb begin
        pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0;
        mdr_in = 1'b0; mdr_out = 1'b0; read = 1'b0; write = 1'b0;
        ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0; z_low_out = 1'b0;
        c_out = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
        r_in = 1'b0; r_out = 1'b0; alu_op = ALU_AND;
        instr_done = 1'b0; illegal_op = 1'b0;
        run = (state != S_RST) && (state != S_HALT);
        case (state)
            S_T0: begin
                pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
                alu_op = ALU_ADD;
            end
            S_T1: begin
                z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1; ir_in = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    C_RTYPE, C_ITYPE: begin
                        grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
                    end
                    C_UNARY: begin
                        grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_code;
                    end
                    C_NOP, C_HALT: instr_done = 1'b1;
                    default: begin
                        illegal_op = 1'b1; instr_done = 1'b1;
                    end
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_RTYPE: begin
                        grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_code;
                    end
                    C_ITYPE: begin
                        c_out = 1'b1; z_in = 1'b1; alu_op = alu_code;
                    end
                    C_UNARY: begin
                        z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1; instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1; instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: two instances (MEM_WAIT 0 and 2) compared
// cycle by cycle against per-instruction strobe schedules built from the opcode table.
module tb_control_sequencer;

    typedef struct packed {
        logic       pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write;
        logic       ir_in, y_in, z_in, z_low_out, c_out, gra, grb, grc, r_in, r_out;
        logic [3:0] alu_op;
        logic       run, instr_done, illegal_op;
    } outs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir = '0;
    wire  [24:0] v0, v2;
    int          total = 0;
    int          passed = 0;
    bit          bus_on = 1'b0;
    outs_t       exp0[$];
    outs_t       exp2[$];

    always #5 clk = ~clk;

    control_sequencer #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .ir(ir),
        .pc_out(v0[24]), .pc_in(v0[23]), .inc_pc(v0[22]), .mar_in(v0[21]),
        .mdr_in(v0[20]), .mdr_out(v0[19]), .read(v0[18]), .write(v0[17]),
        .ir_in(v0[16]), .y_in(v0[15]), .z_in(v0[14]), .z_low_out(v0[13]),
        .c_out(v0[12]), .gra(v0[11]), .grb(v0[10]), .grc(v0[9]),
        .r_in(v0[8]), .r_out(v0[7]), .alu_op(v0[6:3]),
        .run(v0[2]), .instr_done(v0[1]), .illegal_op(v0[0])
    );

    control_sequencer #(.MEM_WAIT(2)) dut2 (
        .clk(clk), .reset(reset), .ir(ir),
        .pc_out(v2[24]), .pc_in(v2[23]), .inc_pc(v2[22]), .mar_in(v2[21]),
        .mdr_in(v2[20]), .mdr_out(v2[19]), .read(v2[18]), .write(v2[17]),
        .ir_in(v2[16]), .y_in(v2[15]), .z_in(v2[14]), .z_low_out(v2[13]),
        .c_out(v2[12]), .gra(v2[11]), .grb(v2[10]), .grc(v2[9]),
        .r_in(v2[8]), .r_out(v2[7]), .alu_op(v2[6:3]),
        .run(v2[2]), .instr_done(v2[1]), .illegal_op(v2[0])
    );

    task automatic check(input string tag, input outs_t obs, input outs_t expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic bus_check(input string tag, input outs_t o);
        int drivers;
        drivers = $countones({o.r_out, o.z_low_out, o.mdr_out, o.pc_out, o.c_out});
        total++;
        assert (drivers <= 1) passed++;
        else $error("FAIL %s: observed %0d bus drivers expected at most 1", tag, drivers);
    endtask

    always @(negedge clk) begin
        if (bus_on) begin
            bus_check("bus_excl_w0", outs_t'(v0));
            bus_check("bus_excl_w2", outs_t'(v2));
        end
    end

    function automatic void push(input outs_t o, input bit which);
        if (which) exp2.push_back(o);
        else       exp0.push_back(o);
    endfunction

    function automatic outs_t step();
        outs_t o = '0;
        o.run = 1'b1;
        return o;
    endfunction

    // Appends one instruction's expected per-cycle outputs; returns 1 if it halts.
    function automatic bit model(input logic [31:0] iv, input int mw, input bit which);
        outs_t o;
        int    kind;
        logic [3:0] op;
        logic [4:0] opc;
        opc = iv[31:27];
        kind = 5; op = 4'b0000;
        case (opc)
            5'd3:  begin kind = 0; op = 4'b0010; end
            5'd4:  begin kind = 0; op = 4'b0011; end
            5'd5:  begin kind = 0; op = 4'b0000; end
            5'd6:  begin kind = 0; op = 4'b0001; end
            5'd7:  begin kind = 0; op = 4'b0100; end
            5'd8:  begin kind = 0; op = 4'b0101; end
            5'd9:  begin kind = 0; op = 4'b0110; end
            5'd10: begin kind = 0; op = 4'b0111; end
            5'd11: begin kind = 1; op = 4'b0010; end
            5'd12: begin kind = 1; op = 4'b0000; end
            5'd13: begin kind = 1; op = 4'b0001; end
            5'd16: begin kind = 2; op = 4'b1010; end
            5'd17: begin kind = 2; op = 4'b1011; end
            5'd25: kind = 3;
            5'd26: kind = 4;
            default: kind = 5;
        endcase
        o = step(); o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1; o.alu_op = 4'b0010;
        push(o, which);
        for (int k = 0; k <= mw; k++) begin
            o = step(); o.z_low_out = 1; o.pc_in = 1; o.read = 1; o.mdr_in = 1;
            push(o, which);
        end
        o = step(); o.mdr_out = 1; o.ir_in = 1;
        push(o, which);
        if (kind <= 1) begin
            o = step(); o.grb = 1; o.r_out = 1; o.y_in = 1;
            push(o, which);
            o = step(); o.z_in = 1; o.alu_op = op;
            if (kind == 0) begin o.grc = 1; o.r_out = 1; end
            else           o.c_out = 1;
            push(o, which);
            o = step(); o.z_low_out = 1; o.gra = 1; o.r_in = 1; o.instr_done = 1;
            push(o, which);
        end else if (kind == 2) begin
            o = step(); o.grb = 1; o.r_out = 1; o.z_in = 1; o.alu_op = op;
            push(o, which);
            o = step(); o.z_low_out = 1; o.gra = 1; o.r_in = 1; o.instr_done = 1;
            push(o, which);
        end else begin
            o = step(); o.instr_done = 1; o.illegal_op = (kind == 5);
            push(o, which);
        end
        if (kind == 4) begin
            for (int k = 0; k < 20; k++) push('0, which);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_w0", outs_t'(v0), '0);
        check("reset_w2", outs_t'(v2), '0);
        reset = 1'b0;
    endtask

    // Runs reps back-to-back copies of one instruction, then checks the next T0.
    task automatic run_seq(input logic [31:0] iv, input int reps, input string tag);
        bit h0, h2;
        int n;
        ir = iv;
        exp0.delete(); exp2.delete();
        h0 = 1'b0; h2 = 1'b0;
        for (int r = 0; r < reps && !h0; r++) begin
            h0 = model(iv, 0, 1'b0);
            h2 = model(iv, 2, 1'b1);
        end
        if (!h0) push(exp0[0], 1'b0);
        if (!h2) push(exp2[0], 1'b1);
        n = (exp0.size() > exp2.size()) ? exp0.size() : exp2.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i < exp0.size()) check($sformatf("%s_w0_c%0d", tag, i), outs_t'(v0), exp0[i]);
            if (i < exp2.size()) check($sformatf("%s_w2_c%0d", tag, i), outs_t'(v2), exp2[i]);
        end
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] add_ir;
        bit          dummy;
        add_ir = 32'h18918000;

        do_reset();
        bus_on = 1'b1;
        run_seq(32'h61080026, 1, "andi");
        do_reset();
        run_seq(add_ir, 2, "add");
        do_reset();
        run_seq({5'b10000, 27'h0123456}, 1, "neg");
        do_reset();
        run_seq({5'b10001, 27'h0654321}, 1, "not");
        do_reset();
        run_seq({5'b11001, 27'h0}, 2, "nop");
        do_reset();
        run_seq({5'b11111, 27'h7ffffff}, 2, "illegal");
        do_reset();
        run_seq({5'b11010, 27'h0}, 1, "halt");

        // Reset asserted during T4 of an add.
        do_reset();
        ir = add_ir;
        exp0.delete(); exp2.delete();
        dummy = model(add_ir, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("midrst_w0_c%0d", i), outs_t'(v0), exp0[i]);
        end
        reset = 1'b1;
        @(negedge clk);
        check("midrst_zero_w0", outs_t'(v0), '0);
        check("midrst_zero_w2", outs_t'(v2), '0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_t0_w0", outs_t'(v0), exp0[0]);
        check("midrst_t0_w2", outs_t'(v2), exp0[0]);

        for (int t = 0; t < 30; t++) begin
            rv = $urandom;
            if ($urandom_range(0, 3) != 0)
                rv[31:27] = 5'($urandom_range(3, 17));
            do_reset();
            run_seq(rv, $urandom_range(1, 3), $sformatf("rand%0d", t));
        end

        bus_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
